// File: rtl/tcm_arb.sv
// ---------------------------------------------------------------------------
// tcm_arb
//
// Controller and two-way arbiter for a single-port TCM SRAM macro. The macro
// has a 1-cycle read latency and byte-masked writes, and cannot read and write
// in the same cycle. The instruction-fetch port (IFU) only reads. The
// load/store port (LSU) reads and writes.
//
// At most one transaction is outstanding. A new command can be granted in the
// same cycle that the outstanding response handshakes, so back-to-back
// accesses run at one per cycle. A stalled read response is copied into a
// holding buffer, because the SRAM output is not stable across cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ifu_cmd_*           IFU read command   (valid/ready, byte address)
//   ifu_rsp_*           IFU read response  (valid/ready, data)
//   lsu_cmd_*           LSU command        (valid/ready, addr, read, wdata, wmask)
//   lsu_rsp_*           LSU response       (valid/ready, data; 0 for write ack)
//   ram_addr/we/wem/din SRAM command side
//   ram_dout            SRAM read data, valid the cycle after a read
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid (and its payload) stable until
// that transfer. cmd_ready is combinational: it is only raised to the
// requester that wins arbitration, and only when a grant is allowed.
// ---------------------------------------------------------------------------
module tcm_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MW         = 4,
    parameter int RAM_AW     = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_cmd_valid,
    output logic              ifu_cmd_ready,
    input  logic [AW-1:0]     ifu_cmd_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DW-1:0]     ifu_rsp_rdata,

    input  logic              lsu_cmd_valid,
    output logic              lsu_cmd_ready,
    input  logic [AW-1:0]     lsu_cmd_addr,
    input  logic              lsu_cmd_read,
    input  logic [DW-1:0]     lsu_cmd_wdata,
    input  logic [MW-1:0]     lsu_cmd_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DW-1:0]     lsu_rsp_rdata,

    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [MW-1:0]     ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing outstanding
        ST_LIVE = 2'd1,   // response cycle, data straight from ram_dout
        ST_HOLD = 2'd2    // response stalled, data from the holding buffer
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            src_lsu_q, src_lsu_d;   // owner of the outstanding access: 1=LSU, 0=IFU
    logic            rd_q, rd_d;             // 1 = outstanding access is a read
    logic [DW-1:0]   buf_q, buf_d;           // holding buffer for a stalled response
    logic [SW-1:0]   starve_q, starve_d;     // LSU grants made while the IFU waited

    // -----------------------------------------------------------------------
    // Word index extraction; the byte offset and upper address bits are
    // deliberately not used.
    // -----------------------------------------------------------------------
    logic [RAM_AW-1:0] ifu_idx;
    logic [RAM_AW-1:0] lsu_idx;
    logic              unused_addr_bits;

    assign ifu_idx = ifu_cmd_addr[RAM_AW+1:2];
    assign lsu_idx = lsu_cmd_addr[RAM_AW+1:2];
    assign unused_addr_bits = ^{ifu_cmd_addr[1:0], lsu_cmd_addr[1:0],
                                ifu_cmd_addr[AW-1:RAM_AW+2], lsu_cmd_addr[AW-1:RAM_AW+2]};

    // -----------------------------------------------------------------------
    // Response side
    // -----------------------------------------------------------------------
    logic          busy;
    logic          owner_rsp_ready;
    logic          rsp_hs;
    logic [DW-1:0] rsp_data;

    always_comb begin
        busy            = (state_q != ST_IDLE);
        owner_rsp_ready = src_lsu_q ? lsu_rsp_ready : ifu_rsp_ready;
        // The owner's rsp_valid is high in every busy state, so the handshake
        // only needs the owner's ready.
        rsp_hs          = busy && owner_rsp_ready;

        rsp_data = '0;
        if (state_q == ST_HOLD) begin
            rsp_data = buf_q;
        end else if (state_q == ST_LIVE && rd_q) begin
            rsp_data = ram_dout;
        end
    end

    always_comb begin
        ifu_rsp_valid = busy && !src_lsu_q;
        lsu_rsp_valid = busy &&  src_lsu_q;
        ifu_rsp_rdata = ifu_rsp_valid ? rsp_data : '0;
        lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : '0;
    end

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic grant_ok;
    logic ifu_pick;
    logic lsu_pick;
    logic ifu_gnt;
    logic lsu_gnt;
    logic any_gnt;

    always_comb begin
        // rst_n gates the grant so that cmd_ready and ram_we drop immediately
        // on reset assertion, without waiting for a clock edge.
        grant_ok = rst_n && (!busy || rsp_hs);

        // The LSU normally wins. The IFU wins when it is the only requester,
        // or once the LSU has used up its run of grants.
        ifu_pick = ifu_cmd_valid && (!lsu_cmd_valid || (starve_q == STARVE_SAT));
        lsu_pick = lsu_cmd_valid && !ifu_pick;

        ifu_gnt  = grant_ok && ifu_pick;
        lsu_gnt  = grant_ok && lsu_pick;
        any_gnt  = ifu_gnt || lsu_gnt;
    end

    assign ifu_cmd_ready = ifu_gnt;
    assign lsu_cmd_ready = lsu_gnt;

    // -----------------------------------------------------------------------
    // SRAM drive
    // -----------------------------------------------------------------------
    // The index follows the arbitration winner and defaults to the IFU. While
    // a response is pending and nothing is granted, the SRAM may re-read an
    // arbitrary word. That is harmless because a stalled response is served
    // from buf_q.
    always_comb begin
        ram_addr = lsu_pick ? lsu_idx : ifu_idx;
        ram_we   = lsu_gnt && !lsu_cmd_read;
        ram_wem  = ram_we ? lsu_cmd_wmask : '0;
        ram_din  = lsu_cmd_wdata;
    end

    // -----------------------------------------------------------------------
    // Starvation counter
    // -----------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (!ifu_cmd_valid || ifu_gnt) begin
            starve_d = '0;
        end else if (lsu_gnt && (starve_q != STARVE_SAT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        src_lsu_d = src_lsu_q;
        rd_d      = rd_q;
        buf_d     = buf_q;

        case (state_q)
            ST_IDLE: begin
                if (any_gnt) begin
                    state_d = ST_LIVE;
                end
            end
            ST_LIVE: begin
                if (rsp_hs) begin
                    state_d = any_gnt ? ST_LIVE : ST_IDLE;
                end else begin
                    // The SRAM output only lasts one cycle, so keep a copy.
                    buf_d   = rsp_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rsp_hs) begin
                    state_d = any_gnt ? ST_LIVE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (any_gnt) begin
            src_lsu_d = lsu_gnt;
            rd_d      = lsu_gnt ? lsu_cmd_read : 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_lsu_q <= 1'b0;
            rd_q      <= 1'b0;
            buf_q     <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            src_lsu_q <= src_lsu_d;
            rd_q      <= rd_d;
            buf_q     <= buf_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_tcm_arb.sv
// ---------------------------------------------------------------------------
// tb_tcm_arb: directed bench for tcm_arb with a behavioural SRAM model.
// When a grant is observed, the driver pushes the expected response data onto
// a per-port queue. A monitor pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_tcm_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int RAM_AW = 9;
    localparam int STARVE_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              ifu_cmd_valid, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [AW-1:0]     ifu_cmd_addr;
    logic [DW-1:0]     ifu_rsp_rdata;
    logic              lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read, lsu_rsp_valid, lsu_rsp_ready;
    logic [AW-1:0]     lsu_cmd_addr;
    logic [DW-1:0]     lsu_cmd_wdata, lsu_rsp_rdata;
    logic [MW-1:0]     lsu_cmd_wmask;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [MW-1:0]     ram_wem;
    logic [DW-1:0]     ram_din, ram_dout;

    tcm_arb #(
        .AW(AW), .DW(DW), .MW(MW), .RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready),
        .ifu_cmd_addr(ifu_cmd_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready),
        .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_read(lsu_cmd_read),
        .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // ---------------- SRAM model ----------------
    logic [DW-1:0] mem [0:(1<<RAM_AW)-1];

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [DW-1:0] ifu_exp_q[$];
    logic [DW-1:0] lsu_exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every response handshake against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifu_rsp_valid && lsu_rsp_valid)
                chk("both_rsp_valid", 32'(1), 32'(0));
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                if (ifu_exp_q.size() == 0) chk("ifu_rsp_unexpected", ifu_rsp_rdata, 32'hx);
                else chk("ifu_rsp_rdata", ifu_rsp_rdata, ifu_exp_q.pop_front());
            end
            if (lsu_rsp_valid && lsu_rsp_ready) begin
                if (lsu_exp_q.size() == 0) chk("lsu_rsp_unexpected", lsu_rsp_rdata, 32'hx);
                else chk("lsu_rsp_rdata", lsu_rsp_rdata, lsu_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        ifu_cmd_valid = 0; ifu_cmd_addr = '0; ifu_rsp_ready = 1;
        lsu_cmd_valid = 0; lsu_cmd_addr = '0; lsu_cmd_read = 1;
        lsu_cmd_wdata = '0; lsu_cmd_wmask = '0; lsu_rsp_ready = 1;
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = '0;
        mem[0] = 32'h0000_00A0;
        mem[1] = 32'h0000_00A1;
        mem[2] = 32'h0000_0013;
        mem[3] = 32'h1234_5678;

        // ---- reset state: requests present but nothing may be granted ----
        repeat (2) @(posedge clk);
        #1;
        ifu_cmd_valid = 1; lsu_cmd_valid = 1; lsu_cmd_read = 0; lsu_cmd_wmask = 4'hF;
        #1;
        chk("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(0));
        chk("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(0));
        chk("rst_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'(0));
        chk("rst_lsu_cmd_ready", 32'(lsu_cmd_ready), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_ram_wem", 32'(ram_wem), 32'(0));
        ifu_cmd_valid = 0; lsu_cmd_valid = 0; lsu_cmd_read = 1; lsu_cmd_wmask = '0;
        next_cycle();
        rst_n = 1;
        next_cycle();

        // ---- LSU write then read of 0x10 ----
        lsu_cmd_valid = 1; lsu_cmd_read = 0; lsu_cmd_addr = 32'h10;
        lsu_cmd_wdata = 32'hAABBCCDD; lsu_cmd_wmask = 4'b0101;
        @(negedge clk);
        chk("wr_cmd_ready", 32'(lsu_cmd_ready), 32'(1));
        chk("wr_ram_addr", 32'(ram_addr), 32'(4));
        chk("wr_ram_we", 32'(ram_we), 32'(1));
        chk("wr_ram_wem", 32'(ram_wem), 32'(4'b0101));
        chk("wr_ram_din", ram_din, 32'hAABBCCDD);
        lsu_exp_q.push_back(32'h0);
        next_cycle();
        lsu_cmd_read = 1;
        @(negedge clk);
        chk("rd_cmd_ready", 32'(lsu_cmd_ready), 32'(1));
        chk("rd_ram_we", 32'(ram_we), 32'(0));
        chk("rd_ram_wem", 32'(ram_wem), 32'(0));
        chk("rd_ram_addr", 32'(ram_addr), 32'(4));
        lsu_exp_q.push_back(32'h00BB00DD);
        next_cycle();
        lsu_cmd_valid = 0;
        @(negedge clk);
        chk("rd_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(1));
        chk("idle_ifu_rdata", ifu_rsp_rdata, 32'h0);
        next_cycle();

        // ---- IFU back-to-back reads of 0x0, 0x4, 0x8 ----
        ifu_cmd_valid = 1;
        for (int i = 0; i < 3; i++) begin
            ifu_cmd_addr = 32'(i * 4);
            @(negedge clk);
            chk("b2b_ifu_cmd_ready", 32'(ifu_cmd_ready), 32'(1));
            if (i > 0) chk("b2b_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(1));
            case (i)
                0: ifu_exp_q.push_back(32'h0000_00A0);
                1: ifu_exp_q.push_back(32'h0000_00A1);
                default: ifu_exp_q.push_back(32'h0000_0013);
            endcase
            next_cycle();
        end
        ifu_cmd_valid = 0;
        @(negedge clk);
        chk("b2b_last_rsp_valid", 32'(ifu_rsp_valid), 32'(1));
        next_cycle();

        // ---- IFU read of 0x8 stalled for 3 cycles; LSU write blocked meanwhile ----
        ifu_rsp_ready = 0; ifu_cmd_valid = 1; ifu_cmd_addr = 32'h8;
        @(negedge clk);
        chk("hold_cmd_ready", 32'(ifu_cmd_ready), 32'(1));
        ifu_exp_q.push_back(32'h0000_0013);
        next_cycle();
        ifu_cmd_valid = 0;
        lsu_cmd_valid = 1; lsu_cmd_read = 0; lsu_cmd_addr = 32'h20;
        lsu_cmd_wdata = 32'hDEADBEEF; lsu_cmd_wmask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(ifu_rsp_valid), 32'(1));
            chk("hold_rsp_rdata", ifu_rsp_rdata, 32'h0000_0013);
            chk("hold_lsu_cmd_ready", 32'(lsu_cmd_ready), 32'(0));
            chk("hold_ram_we", 32'(ram_we), 32'(0));
            next_cycle();
        end
        lsu_cmd_valid = 0; lsu_cmd_read = 1; lsu_cmd_wmask = '0;
        ifu_rsp_ready = 1;
        next_cycle();
        @(negedge clk);
        chk("hold_exit_idle", 32'(ifu_rsp_valid), 32'(0));
        next_cycle();

        // ---- reset while a response of 0x12345678 sits in the buffer ----
        ifu_rsp_ready = 0; ifu_cmd_valid = 1; ifu_cmd_addr = 32'hC;
        @(negedge clk);
        chk("rsthold_cmd_ready", 32'(ifu_cmd_ready), 32'(1));
        next_cycle();
        ifu_cmd_valid = 0;
        next_cycle();
        @(negedge clk);
        chk("rsthold_buffered", ifu_rsp_rdata, 32'h1234_5678);
        lsu_cmd_valid = 1; lsu_cmd_read = 0; lsu_cmd_addr = 32'h24; lsu_cmd_wmask = 4'hF;
        #2;
        rst_n = 0;
        #1;
        chk("rsthold_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(0));
        chk("rsthold_ifu_rdata", ifu_rsp_rdata, 32'h0);
        chk("rsthold_lsu_rdata", lsu_rsp_rdata, 32'h0);
        chk("rsthold_lsu_cmd_ready", 32'(lsu_cmd_ready), 32'(0));
        chk("rsthold_ram_we", 32'(ram_we), 32'(0));
        chk("rsthold_ram_wem", 32'(ram_wem), 32'(0));
        lsu_cmd_valid = 0; lsu_cmd_read = 1; lsu_cmd_wmask = '0;
        next_cycle();
        rst_n = 1; ifu_rsp_ready = 1;
        next_cycle();
        ifu_cmd_valid = 1; ifu_cmd_addr = 32'h0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(ifu_cmd_ready), 32'(1));
        ifu_exp_q.push_back(32'h0000_00A0);
        next_cycle();
        ifu_cmd_valid = 0;
        @(negedge clk);
        chk("post_rst_latency", 32'(ifu_rsp_valid), 32'(1));
        next_cycle();

        // ---- both requesters valid: LSU x4 then IFU, repeating ----
        ifu_cmd_valid = 1; ifu_cmd_addr = 32'h8;
        lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 32'h4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((i % 5) != 4) begin
                chk("starve_lsu_gnt", 32'(lsu_cmd_ready), 32'(1));
                chk("starve_ifu_nogrant", 32'(ifu_cmd_ready), 32'(0));
                lsu_exp_q.push_back(32'h0000_00A1);
            end else begin
                chk("starve_ifu_gnt", 32'(ifu_cmd_ready), 32'(1));
                chk("starve_lsu_nogrant", 32'(lsu_cmd_ready), 32'(0));
                ifu_exp_q.push_back(32'h0000_0013);
            end
            next_cycle();
        end
        ifu_cmd_valid = 0; lsu_cmd_valid = 0;
        repeat (3) next_cycle();

        chk("ifu_queue_drained", 32'(ifu_exp_q.size()), 32'(0));
        chk("lsu_queue_drained", 32'(lsu_exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
